umi2axilite: RTL

- UMI device-side to AXI4-Lite manager bridge; the responder counterpart of our AXI4-Lite-to-UMI host converter.
- Accepts single-word UMI read, write and posted-write requests on a device port. Each request becomes one AXI4-Lite transaction to a downstream register or memory subordinate.
- Returns UMI responses carrying the AXI response code.
- One transaction outstanding at a time.

---
 rtl/umi2axilite_pkg.sv | 40 ++++
 rtl/umi2axilite.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/umi2axilite_pkg.sv
// Shared UMI opcode constants and command-field helpers for the UMI-to-AXI4-Lite bridge.
package umi2axilite_pkg;

  localparam logic [4:0] UmiReqRead   = 5'h01;
  localparam logic [4:0] UmiReqWrite  = 5'h03;
  localparam logic [4:0] UmiReqPosted = 5'h05;
  localparam logic [4:0] UmiRespRead  = 5'h02;
  localparam logic [4:0] UmiRespWrite = 5'h04;
  localparam logic [1:0] AxiSlvErr    = 2'b10;

  typedef struct packed {
    logic [4:0] opcode;
    logic [2:0] size;
    logic [7:0] len;
    logic [1:0] prot;
  } umi_cmd_t;

  function automatic umi_cmd_t umi_unpack(input logic [31:0] cmd);
    umi_cmd_t f;
    f.opcode = cmd[4:0];
    f.size   = cmd[7:5];
    f.len    = cmd[15:8];
    f.prot   = cmd[21:20];
    return f;
  endfunction

  // Responses carry only opcode, len, prot, eom and err; every other field is zero.
  function automatic logic [31:0] umi_pack_resp(input logic [4:0] opcode, input logic [7:0] len,
                                                input logic [1:0] prot, input logic [1:0] err);
    logic [31:0] c;
    c        = '0;
    c[4:0]   = opcode;
    c[15:8]  = len;
    c[21:20] = prot;
    c[22]    = 1'b1;
    c[26:25] = err;
    return c;
  endfunction

endpackage

// File: rtl/umi2axilite.sv
// UMI device port to AXI4-Lite manager bridge: one single-word transaction in flight at a time.
module umi2axilite
  import umi2axilite_pkg::*;
#(
  parameter int unsigned CW = 32,
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            udev_req_valid,
  input  logic [CW-1:0]   udev_req_cmd,
  input  logic [AW-1:0]   udev_req_dstaddr,
  input  logic [AW-1:0]   udev_req_srcaddr,
  input  logic [DW-1:0]   udev_req_data,
  output logic            udev_req_ready,
  output logic            udev_resp_valid,
  output logic [CW-1:0]   udev_resp_cmd,
  output logic [AW-1:0]   udev_resp_dstaddr,
  output logic [AW-1:0]   udev_resp_srcaddr,
  output logic [DW-1:0]   udev_resp_data,
  input  logic            udev_resp_ready,
  output logic [AW-1:0]   axi_awaddr,
  output logic [2:0]      axi_awprot,
  output logic            axi_awvalid,
  input  logic            axi_awready,
  output logic [DW-1:0]   axi_wdata,
  output logic [DW/8-1:0] axi_wstrb,
  output logic            axi_wvalid,
  input  logic            axi_wready,
  input  logic [1:0]      axi_bresp,
  input  logic            axi_bvalid,
  output logic            axi_bready,
  output logic [AW-1:0]   axi_araddr,
  output logic [2:0]      axi_arprot,
  output logic            axi_arvalid,
  input  logic            axi_arready,
  input  logic [DW-1:0]   axi_rdata,
  input  logic [1:0]      axi_rresp,
  input  logic            axi_rvalid,
  output logic            axi_rready
);

  localparam int unsigned NBytes = DW / 8;
  localparam int unsigned DwLog  = $clog2(NBytes);

  typedef enum logic [2:0] {StIdle, StWrite, StBwait, StRead, StRwait, StResp} state_e;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              posted_q, posted_d;
  logic              is_read_q, is_read_d;
  logic [1:0]        err_q, err_d;
  logic [7:0]        len_q, len_d;
  logic [1:0]        prot_q, prot_d;
  logic [AW-1:0]     dstaddr_q, dstaddr_d;
  logic [AW-1:0]     srcaddr_q, srcaddr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [NBytes-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  umi_cmd_t          req;
  logic [DwLog-1:0]  req_lane;
  logic [DwLog-1:0]  cur_lane;
  logic [9:0]        req_end;
  logic              req_legal;
  logic [NBytes-1:0] req_strb;

  // A request is legal only if it is a single word-sized access that stays inside one bus word.
  always_comb begin
    req       = umi_unpack(udev_req_cmd);
    req_lane  = udev_req_dstaddr[DwLog-1:0];
    req_end   = 10'(req_lane) + 10'(req.len) + 10'd1;
    req_legal = (req.size == 3'd0) && (req_end <= 10'(NBytes));
    for (int unsigned i = 0; i < NBytes; i++) begin
      req_strb[i] = (10'(i) >= 10'(req_lane)) && (10'(i) < req_end);
    end
  end

  assign cur_lane = dstaddr_q[DwLog-1:0];

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    resp_valid_d = resp_valid_q;
    posted_d     = posted_q;
    is_read_d    = is_read_q;
    err_d        = err_q;
    len_d        = len_q;
    prot_d       = prot_q;
    dstaddr_d    = dstaddr_q;
    srcaddr_d    = srcaddr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      StIdle: begin
        req_ready_d = 1'b1;
        if (udev_req_valid && req_ready_q) begin
          dstaddr_d = udev_req_dstaddr;
          srcaddr_d = udev_req_srcaddr;
          len_d     = req.len;
          prot_d    = req.prot;
          addr_d    = {udev_req_dstaddr[AW-1:DwLog], {DwLog{1'b0}}};
          wdata_d   = udev_req_data << {req_lane, 3'b000};
          wstrb_d   = req_strb;
          rdata_d   = '0;
          err_d     = 2'b00;
          posted_d  = (req.opcode == UmiReqPosted);
          is_read_d = 1'b0;
          if (req_legal && req.opcode == UmiReqRead) begin
            state_d     = StRead;
            req_ready_d = 1'b0;
            arvalid_d   = 1'b1;
            is_read_d   = 1'b1;
          end else if (req_legal && (req.opcode == UmiReqWrite || req.opcode == UmiReqPosted)) begin
            state_d     = StWrite;
            req_ready_d = 1'b0;
            awvalid_d   = 1'b1;
            wvalid_d    = 1'b1;
          end else if (!(req.opcode == UmiReqPosted || !req.opcode[0])) begin
            state_d      = StResp;
            req_ready_d  = 1'b0;
            resp_valid_d = 1'b1;
            err_d        = AxiSlvErr;
          end
          // Illegal posted or response-class requests fall through and are silently dropped.
        end
      end
      StWrite: begin
        if (axi_awready) awvalid_d = 1'b0;
        if (axi_wready) wvalid_d = 1'b0;
        if ((!awvalid_q || axi_awready) && (!wvalid_q || axi_wready)) begin
          state_d  = StBwait;
          bready_d = 1'b1;
        end
      end
      StBwait: begin
        if (axi_bvalid) begin
          bready_d = 1'b0;
          err_d    = axi_bresp;
          if (posted_q) begin
            state_d     = StIdle;
            req_ready_d = 1'b1;
          end else begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (axi_arready) begin
          state_d   = StRwait;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      StRwait: begin
        if (axi_rvalid) begin
          state_d      = StResp;
          rready_d     = 1'b0;
          resp_valid_d = 1'b1;
          rdata_d      = axi_rdata >> {cur_lane, 3'b000};
          err_d        = axi_rresp;
        end
      end
      StResp: begin
        if (udev_resp_ready) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      posted_q     <= 1'b0;
      is_read_q    <= 1'b0;
      err_q        <= '0;
      len_q        <= '0;
      prot_q       <= '0;
      dstaddr_q    <= '0;
      srcaddr_q    <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      resp_valid_q <= resp_valid_d;
      posted_q     <= posted_d;
      is_read_q    <= is_read_d;
      err_q        <= err_d;
      len_q        <= len_d;
      prot_q       <= prot_d;
      dstaddr_q    <= dstaddr_d;
      srcaddr_q    <= srcaddr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
    end
  end

  assign udev_req_ready    = req_ready_q;
  assign udev_resp_valid   = resp_valid_q;
  assign udev_resp_cmd     = umi_pack_resp(is_read_q ? UmiRespRead : UmiRespWrite,
                                           len_q, prot_q, err_q);
  assign udev_resp_dstaddr = srcaddr_q;
  assign udev_resp_srcaddr = dstaddr_q;
  assign udev_resp_data    = rdata_q;
  assign axi_awaddr        = addr_q;
  assign axi_awprot        = {1'b0, prot_q};
  assign axi_awvalid       = awvalid_q;
  assign axi_wdata         = wdata_q;
  assign axi_wstrb         = wstrb_q;
  assign axi_wvalid        = wvalid_q;
  assign axi_bready        = bready_q;
  assign axi_araddr        = addr_q;
  assign axi_arprot        = {1'b0, prot_q};
  assign axi_arvalid       = arvalid_q;
  assign axi_rready        = rready_q;

endmodule
